regfile_sequencer: RTL and testbench
====================================

Name: regfile_sequencer

Overview:
Multi-step instruction sequencer that drives the register file's access interface (ENW, ENR0, ENR1, WRA, RDA0, RDA1). It also drives the bus-source select and ALU strobes of the 10-bit datapath. It accepts one 10-bit instruction per Exec handshake and walks timesteps T0–T2 so that reads, ALU capture and write-back land on the register file's active clock edge. It sits between the instruction input switches and the datapath.

Parameters:
DATA_W, 10, instruction/data word width
ADDR_W, 2, register address width (4 registers)

Ports:
CLKb  input  1  debounced clock; all state changes on its falling edge
Clrn  input  1  reset, asynchronous, active-low
Exec  input  1  level request; instruction accepted when Exec=1 and Ready=1 at the falling edge
Instr  input  DATA_W  instruction: [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] ignored
ENW  output  1  register-file write enable
WRA  output  ADDR_W  write address
ENR0  output  1  read enable, port 0
RDA0  output  ADDR_W  read address, port 0
ENR1  output  1  read enable, port 1
RDA1  output  ADDR_W  read address, port 1
BusSel  output  2  datapath bus source: 0 none, 1 Q0, 2 external data, 3 ALU result G
AluOp  output  3  ALU function (= opcode[2:0])
Gin  output  1  ALU result register capture strobe
Ready  output  1  idle and able to accept
Done  output  1  one-cycle pulse in the final timestep
Tstep  output  2  current timestep (0–2) for display

Behaviour:
- Reset (Clrn=0, async): state=T0, IR=0. Outputs: ENW/ENR0/ENR1/Gin/Done=0, WRA/RDA0/RDA1=0, BusSel=0, AluOp=0, Tstep=0, Ready=1. Reset mid-instruction aborts it; no ENW is issued.
- All outputs are Moore outputs decoded from (state, IR). They change only after a falling edge or on reset.
- T0: Ready=1, everything else inactive. Exec=1 at the edge latches Instr into IR and moves to T1. Instr is ignored outside T0.
- Opcodes: 0 LOAD, 1 MOV, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOT, 8–15 NOP.
- LOAD, T1: BusSel=2, ENW=1, WRA=Rx, Done=1. Next state T0.
- MOV, T1: ENR0=1, RDA0=Ry, BusSel=1, ENW=1, WRA=Rx, Done=1. Next state T0. Rx==Ry is legal; the register rewrites its own value.
- ALU ops 2–6, T1: ENR0=1, RDA0=Rx, ENR1=1, RDA1=Ry, AluOp=opcode[2:0], Gin=1. Next state T2.
- NOT, T1: same as ALU ops but ENR1=0.
- ALU ops and NOT, T2: BusSel=3, ENW=1, WRA=Rx, Done=1. Next state T0.
- NOP, T1: Done=1 only; ENW=0, no reads. Next state T0.
- ENR0/ENR1 are 0 whenever a read is not needed, so register-file outputs float (Z) and never contend.
- ENW is high for exactly one cycle per writing instruction and never in T0.
- Exec held high is not a new request: back-to-back instructions need Exec sampled again in T0. Minimum spacing is 2 cycles (LOAD/MOV/NOP) or 3 cycles (ALU).
- Tstep equals the state encoding (T0=0, T1=1, T2=2). The encoding value 3 is unreachable; if entered, go to T0 with no outputs asserted.

Decomposition:
- Shared package bitblaster_pkg: opcode_t enum (LOAD..NOP), bussel_t enum (BUS_NONE, BUS_Q0, BUS_EXT, BUS_G), tstep_t enum (T0, T1, T2), DATA_W/ADDR_W constants, and IR field slice positions.
- One sub-module: regfile_seq_decode, purely combinational, mapping (tstep, IR) to all control outputs plus the next-state value. The top holds only the state register and IR.

Test Plan:
1. Clrn pulsed low mid-T2 of ADD → all enables 0, Ready=1, Tstep=0 immediately (before the next edge); no ENW follows.
2. Instr=0x030 (LOAD R3), Exec=1 → T1: ENW=1, WRA=3, BusSel=2, Done=1; next cycle Ready=1.
3. Instr=0x04C (MOV R0,R3) → T1: ENR0=1, RDA0=3, BusSel=1, ENW=1, WRA=0, ENR1=0.
4. Instr=0x098 (ADD R1,R2) → T1: ENR0=1, RDA0=1, ENR1=1, RDA1=2, AluOp=2, Gin=1, ENW=0. T2: BusSel=3, ENW=1, WRA=1, Done=1.
5. Instr=0x1D0 (NOT R1) → T1: ENR0=1, ENR1=0, AluOp=7. Instr=0x3C0 (opcode 15) → T1: Done=1, ENW=0, no reads.
6. Exec held high across 0x0E4 (SUB R2,R1) → exactly one ENW (WRA=2). Changing Instr during T1/T2 has no effect. Next accept occurs in T0 only.

Source files
------------

// File: rtl/bitblaster_pkg.sv
// Shared types and constants for the 10-bit datapath control slice.
// Opcode, bus-source and timestep encodings plus instruction field positions.
package bitblaster_pkg;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 2;

    localparam int OP_HI = 9;
    localparam int OP_LO = 6;
    localparam int RX_HI = 5;
    localparam int RX_LO = 4;
    localparam int RY_HI = 3;
    localparam int RY_LO = 2;

    // Opcodes 8..15 all behave as NOP; only 8 is named.
    typedef enum logic [3:0] {
        OP_LOAD = 4'd0,
        OP_MOV  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOT  = 4'd7,
        OP_NOP  = 4'd8
    } opcode_t;

    typedef enum logic [1:0] {
        BUS_NONE = 2'd0,
        BUS_Q0   = 2'd1,
        BUS_EXT  = 2'd2,
        BUS_G    = 2'd3
    } bussel_t;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2
    } tstep_t;

endpackage

// File: rtl/regfile_seq_decode.sv
// Combinational control decode: maps (timestep, IR) to register-file,
// bus and ALU controls, and computes the next timestep.
module regfile_seq_decode
    import bitblaster_pkg::*;
(
    input  tstep_t             state,
    input  logic [DATA_W-1:0]  ir,
    input  logic               exec,
    output tstep_t             next_state,
    output logic               enw,
    output logic [ADDR_W-1:0]  wra,
    output logic               enr0,
    output logic [ADDR_W-1:0]  rda0,
    output logic               enr1,
    output logic [ADDR_W-1:0]  rda1,
    output bussel_t            bus_sel,
    output logic [2:0]         alu_op,
    output logic               gin,
    output logic               ready,
    output logic               done
);

    logic [3:0]        op;
    logic [ADDR_W-1:0] rx;
    logic [ADDR_W-1:0] ry;
    logic              unused_ir_bits;

    assign op             = ir[OP_HI:OP_LO];
    assign rx             = ir[RX_HI:RX_LO];
    assign ry             = ir[RY_HI:RY_LO];
    assign unused_ir_bits = ^ir[1:0];

    // Addresses stay at zero whenever their enable is low.
    always_comb begin
        next_state = T0;
        enw        = 1'b0;
        wra        = '0;
        enr0       = 1'b0;
        rda0       = '0;
        enr1       = 1'b0;
        rda1       = '0;
        bus_sel    = BUS_NONE;
        alu_op     = 3'd0;
        gin        = 1'b0;
        ready      = 1'b0;
        done       = 1'b0;

        case (state)
            T0: begin
                ready      = 1'b1;
                next_state = exec ? T1 : T0;
            end
            T1: begin
                case (op)
                    OP_LOAD: begin
                        bus_sel = BUS_EXT;
                        enw     = 1'b1;
                        wra     = rx;
                        done    = 1'b1;
                    end
                    OP_MOV: begin
                        enr0    = 1'b1;
                        rda0    = ry;
                        bus_sel = BUS_Q0;
                        enw     = 1'b1;
                        wra     = rx;
                        done    = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                        enr0       = 1'b1;
                        rda0       = rx;
                        enr1       = (op != OP_NOT);
                        rda1       = (op != OP_NOT) ? ry : '0;
                        alu_op     = op[2:0];
                        gin        = 1'b1;
                        next_state = T2;
                    end
                    default: begin
                        done = 1'b1;
                    end
                endcase
            end
            T2: begin
                bus_sel = BUS_G;
                enw     = 1'b1;
                wra     = rx;
                done    = 1'b1;
            end
            default: begin
                next_state = T0;
            end
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Instruction sequencer for the register-file datapath: holds the timestep
// register and IR, clocked on the falling edge of the debounced clock.
module regfile_sequencer
    import bitblaster_pkg::*;
(
    input  logic               CLKb,
    input  logic               Clrn,
    input  logic               Exec,
    input  logic [DATA_W-1:0]  Instr,
    output logic               ENW,
    output logic [ADDR_W-1:0]  WRA,
    output logic               ENR0,
    output logic [ADDR_W-1:0]  RDA0,
    output logic               ENR1,
    output logic [ADDR_W-1:0]  RDA1,
    output logic [1:0]         BusSel,
    output logic [2:0]         AluOp,
    output logic               Gin,
    output logic               Ready,
    output logic               Done,
    output logic [1:0]         Tstep
);

    tstep_t            state;
    tstep_t            next_state;
    bussel_t           bus_sel;
    logic [DATA_W-1:0] ir;

    // Instr is only captured on an accepted request in T0.
    always_ff @(negedge CLKb or negedge Clrn) begin
        if (!Clrn) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == T0 && Exec) begin
                ir <= Instr;
            end
        end
    end

    regfile_seq_decode u_decode (
        .state      (state),
        .ir         (ir),
        .exec       (Exec),
        .next_state (next_state),
        .enw        (ENW),
        .wra        (WRA),
        .enr0       (ENR0),
        .rda0       (RDA0),
        .enr1       (ENR1),
        .rda1       (RDA1),
        .bus_sel    (bus_sel),
        .alu_op     (AluOp),
        .gin        (Gin),
        .ready      (Ready),
        .done       (Done)
    );

    assign BusSel = bus_sel;
    assign Tstep  = state;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: directed literal checks plus randomized
// traffic compared every cycle against a per-instruction cycle-program model.
module tb_regfile_sequencer;

    logic       CLKb  = 1'b1;
    logic       Clrn  = 1'b0;
    logic       Exec  = 1'b0;
    logic [9:0] Instr = '0;

    logic       ENW, ENR0, ENR1, Gin, Ready, Done;
    logic [1:0] WRA, RDA0, RDA1, BusSel, Tstep;
    logic [2:0] AluOp;

    int compared   = 0;
    int mismatched = 0;

    regfile_sequencer dut (
        .CLKb   (CLKb),
        .Clrn   (Clrn),
        .Exec   (Exec),
        .Instr  (Instr),
        .ENW    (ENW),
        .WRA    (WRA),
        .ENR0   (ENR0),
        .RDA0   (RDA0),
        .ENR1   (ENR1),
        .RDA1   (RDA1),
        .BusSel (BusSel),
        .AluOp  (AluOp),
        .Gin    (Gin),
        .Ready  (Ready),
        .Done   (Done),
        .Tstep  (Tstep)
    );

    always #5 CLKb = ~CLKb;

    typedef struct packed {
        logic       enw;
        logic [1:0] wra;
        logic       enr0;
        logic [1:0] rda0;
        logic       enr1;
        logic [1:0] rda1;
        logic [1:0] bussel;
        logic [2:0] aluop;
        logic       gin;
        logic       ready;
        logic       done;
        logic [1:0] tstep;
    } out_t;

    // Each accepted instruction expands into the list of cycles it occupies.
    out_t exp_q[$];

    function automatic out_t idle_out();
        out_t o = '0;
        o.ready = 1'b1;
        return o;
    endfunction

    function automatic void push_program(input logic [9:0] ins);
        int   op = int'(ins[9:6]);
        out_t a  = '0;
        out_t b  = '0;
        a.tstep = 2'd1;
        if (op == 0) begin
            a.bussel = 2'd2; a.enw = 1'b1; a.wra = ins[5:4]; a.done = 1'b1;
            exp_q.push_back(a);
        end else if (op == 1) begin
            a.enr0 = 1'b1; a.rda0 = ins[3:2]; a.bussel = 2'd1;
            a.enw = 1'b1; a.wra = ins[5:4]; a.done = 1'b1;
            exp_q.push_back(a);
        end else if (op >= 2 && op <= 7) begin
            a.enr0 = 1'b1; a.rda0 = ins[5:4];
            a.enr1 = (op != 7); a.rda1 = ins[3:2];
            a.aluop = ins[8:6]; a.gin = 1'b1;
            b.tstep = 2'd2; b.bussel = 2'd3; b.enw = 1'b1;
            b.wra = ins[5:4]; b.done = 1'b1;
            exp_q.push_back(a);
            exp_q.push_back(b);
        end else begin
            a.done = 1'b1;
            exp_q.push_back(a);
        end
    endfunction

    always @(negedge CLKb or negedge Clrn) begin
        if (!Clrn) begin
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            if (Exec) push_program(Instr);
        end else begin
            void'(exp_q.pop_front());
        end
    end

    function automatic out_t dut_out();
        out_t o;
        o.enw = ENW;   o.wra = WRA;   o.enr0 = ENR0; o.rda0 = RDA0;
        o.enr1 = ENR1; o.rda1 = RDA1; o.bussel = BusSel; o.aluop = AluOp;
        o.gin = Gin;   o.ready = Ready; o.done = Done; o.tstep = Tstep;
        return o;
    endfunction

    // Addresses and AluOp are don't-care while their strobe is low mid-instruction.
    function automatic out_t mask_dont_care(input out_t a, input out_t e);
        out_t m = a;
        if (!e.ready) begin
            if (!e.enw)  m.wra   = e.wra;
            if (!e.enr0) m.rda0  = e.rda0;
            if (!e.enr1) m.rda1  = e.rda1;
            if (!e.gin)  m.aluop = e.aluop;
        end
        return m;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge CLKb) begin
        if (Clrn) begin
            out_t e;
            e = (exp_q.size() != 0) ? exp_q[0] : idle_out();
            checkOutput("model", int'(mask_dont_care(dut_out(), e)), int'(e));
        end
    end

    task automatic applyStimulus(input logic [9:0] ins, input int hold);
        @(posedge CLKb);
        #1;
        Instr = ins;
        Exec  = 1'b1;
        @(negedge CLKb);
        #1;
        repeat (hold) begin
            Instr = 10'($urandom);
            @(negedge CLKb);
            #1;
        end
        Exec  = 1'b0;
        Instr = 10'($urandom);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (Ready !== 1'b1 && n < 10) begin
            @(posedge CLKb);
            n++;
        end
        if (n >= 10) checkOutput("idle_timeout", int'(Ready), 1);
    endtask

    task automatic checkIdleNow(input string tag);
        checkOutput({tag, "_ready"}, int'(Ready), 1);
        checkOutput({tag, "_tstep"}, int'(Tstep), 0);
        checkOutput({tag, "_enables"}, int'({ENW, ENR0, ENR1, Gin, Done}), 0);
        checkOutput({tag, "_addr"}, int'({WRA, RDA0, RDA1}), 0);
        checkOutput({tag, "_bus_alu"}, int'({BusSel, AluOp}), 0);
    endtask

    initial begin
        #12;
        checkIdleNow("reset");
        #1 Clrn = 1'b1;

        // LOAD R3
        applyStimulus(10'h030, 0);
        @(posedge CLKb);
        checkOutput("load_enw", int'(ENW), 1);
        checkOutput("load_wra", int'(WRA), 3);
        checkOutput("load_bus", int'(BusSel), 2);
        checkOutput("load_done", int'(Done), 1);
        checkOutput("load_ready", int'(Ready), 0);
        @(posedge CLKb);
        checkOutput("load_after_ready", int'(Ready), 1);

        // MOV R0,R3
        applyStimulus(10'h04C, 0);
        @(posedge CLKb);
        checkOutput("mov_enr0", int'(ENR0), 1);
        checkOutput("mov_rda0", int'(RDA0), 3);
        checkOutput("mov_bus", int'(BusSel), 1);
        checkOutput("mov_enw_wra", int'({ENW, WRA}), 3'b100);
        checkOutput("mov_enr1", int'(ENR1), 0);
        waitIdle();

        // ADD R1,R2
        applyStimulus(10'h098, 0);
        @(posedge CLKb);
        checkOutput("add_t1_reads", int'({ENR0, RDA0, ENR1, RDA1}), 6'b101_110);
        checkOutput("add_t1_alu", int'(AluOp), 2);
        checkOutput("add_t1_gin", int'(Gin), 1);
        checkOutput("add_t1_enw", int'(ENW), 0);
        @(posedge CLKb);
        checkOutput("add_t2_bus", int'(BusSel), 3);
        checkOutput("add_t2_enw_wra", int'({ENW, WRA}), 3'b101);
        checkOutput("add_t2_done", int'(Done), 1);
        checkOutput("add_t2_tstep", int'(Tstep), 2);
        waitIdle();

        // NOT R1 and a high NOP
        applyStimulus(10'h1D0, 0);
        @(posedge CLKb);
        checkOutput("not_enr", int'({ENR0, ENR1}), 2'b10);
        checkOutput("not_alu", int'(AluOp), 7);
        waitIdle();
        applyStimulus(10'h3C0, 0);
        @(posedge CLKb);
        checkOutput("nop_done", int'(Done), 1);
        checkOutput("nop_quiet", int'({ENW, ENR0, ENR1, Gin}), 0);
        @(posedge CLKb);
        checkOutput("nop_back", int'(Tstep), 0);

        // SUB R2,R1 with Exec held through T1 and Instr scrambled
        applyStimulus(10'h0E4, 1);
        @(posedge CLKb);
        checkOutput("sub_t2_enw_wra", int'({ENW, WRA}), 3'b110);
        checkOutput("sub_t2_tstep", int'(Tstep), 2);
        @(posedge CLKb);
        checkOutput("sub_after_ready", int'(Ready), 1);
        @(posedge CLKb);
        checkOutput("sub_no_repeat", int'({Tstep, ENW}), 0);

        // Async reset in T2 of ADD
        applyStimulus(10'h098, 0);
        @(negedge CLKb);
        #1;
        checkOutput("abort_in_t2", int'(Tstep), 2);
        #2 Clrn = 1'b0;
        #1;
        checkIdleNow("abort");
        Clrn = 1'b1;
        repeat (3) @(posedge CLKb);

        // Randomized traffic with occasional async resets
        repeat (500) begin
            @(posedge CLKb);
            #1;
            Exec  = ($urandom_range(0, 2) != 0);
            Instr = 10'($urandom);
            if ($urandom_range(0, 60) == 0) begin
                #2 Clrn = 1'b0;
                #1 Clrn = 1'b1;
            end
        end
        Exec = 1'b0;
        repeat (4) @(posedge CLKb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
